// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the fetch PC, issues word-addressed fetch requests over a
// valid/ready handshake, applies taken-branch redirects and buffers a redirect
// that lands while the current request is stalled.
module pc_sequencer #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Branch,
  input  logic             Zero,
  input  logic [WIDTH-1:0] PCBranch,
  input  logic             Halt,
  input  logic             FetchReady,
  output logic             FetchValid,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PCPlus1,
  output logic             RedirectPending,
  output logic             Squash,
  output logic [31:0]      FetchCount
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] pend_pc, pend_pc_next;
  logic [WIDTH-1:0] pc_next;
  logic             fetch_valid_next;
  logic             redirect_pending_next;
  logic             squash_next;
  logic [31:0]      fetch_count_next;

  logic accept;
  logic redirect;

  // A request completes when both sides agree in the same cycle.
  assign accept   = FetchValid && FetchReady;
  // While a redirect is buffered, everything in flight is wrong-path, so any
  // further taken branch is ignored.
  assign redirect = Branch && Zero && !RedirectPending;

  // Sequential PC of the current fetch; wraps naturally modulo 2^WIDTH.
  assign PCPlus1 = PC + WIDTH'(1);

  // State register: synchronous reset overrides everything, even mid-handshake.
  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values computed by the combinational block, independent of order.
    if (Reset) begin
      state           <= IDLE;
      PC              <= RESET_PC;
      pend_pc         <= '0;
      FetchValid      <= 1'b0;
      RedirectPending <= 1'b0;
      Squash          <= 1'b0;
      FetchCount      <= '0;
    end else begin
      state           <= state_next;
      PC              <= pc_next;
      pend_pc         <= pend_pc_next;
      FetchValid      <= fetch_valid_next;
      RedirectPending <= redirect_pending_next;
      Squash          <= squash_next;
      FetchCount      <= fetch_count_next;
    end
  end

  // Next-state logic: PC selection in priority order, handshake hold, squash.
  always_comb begin
    // NOTE: every output of this block gets a hold/default value first so no
    // path through the case statement can infer a latch.
    state_next            = state;
    pc_next               = PC;
    pend_pc_next          = pend_pc;
    fetch_valid_next      = FetchValid;
    redirect_pending_next = RedirectPending;
    squash_next           = 1'b0;
    fetch_count_next      = FetchCount;

    unique case (state)
      IDLE: begin
        // First cycle out of reset: start fetching at RESET_PC unless halted.
        state_next       = RUN;
        fetch_valid_next = !Halt;
      end

      RUN: begin
        if (redirect && (accept || !FetchValid)) begin
          // Nothing is stalled, so the target can be taken immediately.
          pc_next = PCBranch;
        end else if (redirect) begin
          // Request is stalled: PC must hold, so park the target.
          pend_pc_next          = PCBranch;
          redirect_pending_next = 1'b1;
        end else if (RedirectPending && accept) begin
          // The stalled wrong-path request finally went out; jump now.
          pc_next               = pend_pc;
          redirect_pending_next = 1'b0;
        end else if (accept) begin
          pc_next = PCPlus1;
        end

        // A stalled request stays valid regardless of Halt; otherwise issue
        // a new request only while not halted.
        fetch_valid_next = (FetchValid && !FetchReady) || !Halt;
        squash_next      = redirect;
        if (accept) begin
          fetch_count_next = FetchCount + 32'd1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule
